// File: rtl/connect_pkg.sv
// Shared encodings for the connect-N game core: cell values, FSM states and
// the per-direction step vectors used by the neighbour scan.
package connect_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [1:0] {IDLE, PLACE, CHECK, OVER} state_t;

  // Scan order: horizontal, vertical, diagonal up-right, diagonal down-right.
  typedef enum logic [1:0] {DIR_H, DIR_V, DIR_UR, DIR_DR} dir_t;

  localparam int STEP_DC [4] = '{1, 0, 1,  1};
  localparam int STEP_DR [4] = '{0, 1, 1, -1};

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for an already-debounced level; the pulse is registered
// so it appears one cycle after the level rises.
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N game state: board, gravity drop, turn order and a sequential
// neighbour scan for WIN_LEN-in-a-row wins and draws.
module connect_n_engine
  import connect_pkg::*;
#(
  parameter  int COLS    = 7,
  parameter  int ROWS    = 6,
  parameter  int WIN_LEN = 4,
  localparam int CW      = $clog2(COLS),
  localparam int RW      = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_drop,
  input  logic [CW-1:0] rd_col,
  input  logic [RW-1:0] rd_row,
  output logic [1:0]    rd_cell,
  output logic [CW-1:0] cursor_col,
  output logic          player,
  output logic          busy,
  output logic          game_over,
  output logic [1:0]    winner
);

  localparam int CELLS = COLS * ROWS;
  localparam int IW    = $clog2(CELLS);
  localparam int HW    = $clog2(ROWS + 1);
  localparam int NW    = $clog2(CELLS + 1);
  localparam int LW    = $clog2(WIN_LEN + 1);

  logic left_p, right_p, drop_p;

  button_edge u_left  (.clk(clk), .rst(rst), .level(btn_left),  .pulse(left_p));
  button_edge u_right (.clk(clk), .rst(rst), .level(btn_right), .pulse(right_p));
  button_edge u_drop  (.clk(clk), .rst(rst), .level(btn_drop),  .pulse(drop_p));

  state_t          state_q, state_d;
  logic [1:0]      board [CELLS];
  logic [HW-1:0]   heights [COLS];
  logic [NW-1:0]   count_q;
  logic [CW-1:0]   cursor_q, tgt_col_q, pos_c_q;
  logic [RW-1:0]   tgt_row_q, pos_r_q;
  logic            player_q, side_q;
  logic [1:0]      winner_q, mover;
  dir_t            dir_q;
  logic [LW-1:0]   side_cnt_q, run_q;

  logic            start_drop, clear_game, move_left, move_right;
  logic            finish_win, finish_turn, hit, side_end, win_now, nb_inb, col_full;
  int              step_c, step_r, nb_c, nb_r;
  logic [IW-1:0]   nb_idx, place_idx, rd_idx;

  assign mover     = player_q ? P2 : P1;
  assign col_full  = (heights[cursor_q] == HW'(ROWS));
  assign place_idx = IW'(int'(tgt_row_q) * COLS + int'(tgt_col_q));
  assign rd_idx    = IW'(int'(rd_row) * COLS + int'(rd_col));
  assign rd_cell   = (int'(rd_col) < COLS && int'(rd_row) < ROWS) ? board[rd_idx] : EMPTY;

  // Neighbour under evaluation: one step from the current walk position.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    step_c = STEP_DC[dir_q];
    step_r = STEP_DR[dir_q];
    if (side_q) begin
      step_c = -step_c;
      step_r = -step_r;
    end
    nb_c     = int'(pos_c_q) + step_c;
    nb_r     = int'(pos_r_q) + step_r;
    nb_inb   = (nb_c >= 0) && (nb_c < COLS) && (nb_r >= 0) && (nb_r < ROWS);
    nb_idx   = nb_inb ? IW'(nb_r * COLS + nb_c) : '0;
    hit      = nb_inb && (board[nb_idx] == mover);
    win_now  = hit && (int'(run_q) + 1 >= WIN_LEN);
    side_end = !hit || (int'(side_cnt_q) + 1 >= WIN_LEN - 1);
  end

  always_comb begin
    state_d     = state_q;
    start_drop  = 1'b0;
    clear_game  = 1'b0;
    move_left   = 1'b0;
    move_right  = 1'b0;
    finish_win  = 1'b0;
    finish_turn = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drop_p) begin
          if (!col_full) begin
            state_d    = PLACE;
            start_drop = 1'b1;
          end
        end else if (left_p && !right_p) begin
          move_left = 1'b1;
        end else if (right_p && !left_p) begin
          move_right = 1'b1;
        end
      end
      PLACE: state_d = CHECK;
      CHECK: begin
        if (win_now) begin
          state_d    = OVER;
          finish_win = 1'b1;
        end else if (side_end && side_q && dir_q == DIR_DR) begin
          if (count_q == NW'(CELLS)) begin
            state_d = OVER;
          end else begin
            state_d     = IDLE;
            finish_turn = 1'b1;
          end
        end
      end
      OVER: begin
        if (drop_p) begin
          state_d    = IDLE;
          clear_game = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_game) begin
      // NOTE: the board is a register file, not a RAM: it must empty in a single cycle and feeds rd_cell combinationally, so every cell is reset.
      for (int i = 0; i < CELLS; i++) board[i] <= EMPTY;
      for (int c = 0; c < COLS; c++) heights[c] <= '0;
      count_q  <= '0;
      cursor_q <= '0;
      player_q <= 1'b0;
      winner_q <= EMPTY;
    end
    if (rst) begin
      tgt_col_q  <= '0;
      tgt_row_q  <= '0;
      pos_c_q    <= '0;
      pos_r_q    <= '0;
      dir_q      <= DIR_H;
      side_q     <= 1'b0;
      side_cnt_q <= '0;
      run_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking <= so every flop samples pre-edge values regardless of statement order.
      if (move_left)  cursor_q <= (cursor_q == '0) ? CW'(COLS - 1) : cursor_q - CW'(1);
      if (move_right) cursor_q <= (cursor_q == CW'(COLS - 1)) ? '0 : cursor_q + CW'(1);
      if (start_drop) begin
        tgt_col_q <= cursor_q;
        tgt_row_q <= RW'(heights[cursor_q]);
      end
      if (state_q == PLACE) begin
        board[place_idx]   <= mover;
        heights[tgt_col_q] <= heights[tgt_col_q] + HW'(1);
        count_q            <= count_q + NW'(1);
        dir_q              <= DIR_H;
        side_q             <= 1'b0;
        side_cnt_q         <= '0;
        run_q              <= LW'(1);
        pos_c_q            <= tgt_col_q;
        pos_r_q            <= tgt_row_q;
      end
      // Walk one neighbour per cycle; a side restarts from the placed piece.
      if (state_q == CHECK) begin
        if (!side_end) begin
          pos_c_q    <= CW'(nb_c);
          pos_r_q    <= RW'(nb_r);
          side_cnt_q <= side_cnt_q + LW'(1);
          run_q      <= run_q + LW'(1);
        end else if (!side_q) begin
          side_q     <= 1'b1;
          side_cnt_q <= '0;
          pos_c_q    <= tgt_col_q;
          pos_r_q    <= tgt_row_q;
          if (hit) run_q <= run_q + LW'(1);
        end else begin
          side_q     <= 1'b0;
          dir_q      <= dir_t'(dir_q + 2'd1);
          side_cnt_q <= '0;
          run_q      <= LW'(1);
          pos_c_q    <= tgt_col_q;
          pos_r_q    <= tgt_row_q;
        end
      end
      if (finish_win)  winner_q <= mover;
      if (finish_turn) player_q <= ~player_q;
    end
  end

  assign cursor_col = cursor_q;
  assign player     = player_q;
  assign busy       = (state_q == PLACE) || (state_q == CHECK);
  assign game_over  = (state_q == OVER);
  assign winner     = winner_q;

endmodule

// File: doc/connect_n_engine.md
# connect_n_engine

Parametrised game-state core for the Connect-Four family: holds a COLS×ROWS board, moves a drop cursor, applies gravity on drop, alternates players, and detects WIN_LEN-in-a-row wins and draws with a sequential neighbour scan. It sits between the button inputs and the VGA renderer. It replaces the fixed 7×6 / four-in-a-row game logic with sizes and win length set at elaboration, plus a combinational read port the renderer polls every pixel.

## Interface
- COLS, default 7: board columns, 4..16.
- ROWS, default 6: board rows, 4..16; row 0 is the bottom.
- WIN_LEN, default 4: run length that wins; 3..min(COLS,ROWS).
- CW = $clog2(COLS), RW = $clog2(ROWS) (derived, not overridable).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset, synchronous and active-high.
- btn_left  in  1  level; already synchronised and debounced upstream.
- btn_right  in  1  level; already synchronised and debounced upstream.
- btn_drop  in  1  level; already synchronised and debounced upstream.
- rd_col  in  CW  renderer read column.
- rd_row  in  RW  renderer read row.
- rd_cell  out  2  combinational cell at (rd_col, rd_row): 00 empty, 01 P1, 10 P2. Out-of-range address returns 00.
- cursor_col  out  CW  current drop column.
- player  out  1  side to move: 0 = P1, 1 = P2.
- busy  out  1  high while the placement/check sequence runs.
- game_over  out  1  high once the game has been won or drawn.
- winner  out  2  01 P1, 10 P2, 00 for no winner or a draw.

## Operation
- Each button has a rising-edge detector. Only edges act; held buttons do not repeat.
- States:
  - IDLE: accepts inputs.
  - PLACE: one cycle; writes the cell, increments the column height and the piece count.
  - CHECK: scans neighbours.
  - OVER: game finished.
- IDLE, priority when several edges arrive in the same cycle:
  - drop beats everything.
  - left and right together are ignored.
  - left: cursor_col−1, wrapping from 0 to COLS−1.
  - right: cursor_col+1, wrapping from COLS−1 to 0.
- Drop on a full column (height == ROWS): ignored. No state change, player unchanged.
- Drop on a non-full column: latch (cursor_col, height) as the target, go to PLACE, then CHECK.
- CHECK walks 4 directions in order: horizontal, vertical, diagonal up-right, diagonal down-right. For each direction it walks the + side and then the − side.
  - Each evaluated neighbour costs one cycle.
  - A side ends on out-of-bounds, on a mismatch, or after WIN_LEN−1 matches.
  - run = 1 + matches on both sides.
  - If run ≥ WIN_LEN, go to OVER immediately (early exit) with winner = the mover.
- No win and piece count == COLS·ROWS: go to OVER with winner = 00 (draw).
- Otherwise flip player and return to IDLE.
- OVER:
  - left and right are ignored.
  - A drop edge clears the board, heights and count in one cycle; cursor goes to 0, player to P1, game_over and winner clear; state returns to IDLE.
- Edges arriving during PLACE/CHECK are discarded, not queued.

## Timing
- Reset values: board all empty, heights 0, count 0, cursor_col 0, player 0, busy 0, game_over 0, winner 00, state IDLE.
- Edge detection has one cycle of latency. The button rises in cycle n and the cursor updates at the end of cycle n+1.
- busy rises the cycle after the drop edge is registered. It covers 1 PLACE cycle plus the CHECK cycles, and falls in the cycle the state leaves CHECK.
- Worst-case CHECK length is 8·(WIN_LEN−1) cycles.
- game_over, winner and the player flip update on the same clock edge that leaves CHECK.
- rd_cell reflects a new piece in the cycle after PLACE.
- rst asserted mid-CHECK or in OVER: all registers take their reset values on the next edge. No partial write survives.
- Count and height arithmetic never exceeds its range. Height saturates at ROWS by construction because full columns are rejected.

## Structure
- Package connect_pkg holds:
  - cell encoding constants (EMPTY, P1, P2).
  - state enum (IDLE, PLACE, CHECK, OVER).
  - direction enum and per-direction (dc, dr) step constants.
- Sub-module button_edge: registered previous level plus a rising-edge pulse output, instanced three times.
- The board is a flat register array of COLS·ROWS 2-bit cells. Heights are a COLS×$clog2(ROWS+1) array.

## Test plan
- Cursor wrap: reset, press left once → cursor_col 6. Press right twice → cursor_col 1. Left and right pressed in the same cycle → cursor unchanged.
- Gravity and turn: drop in column 3 three times → rd_cell at (3,0)=01, (3,1)=10, (3,2)=01, and player returns to 1. Fill column 3 to 6 pieces; a 7th drop leaves player and board unchanged and busy stays 0.
- Vertical win: P1 drops in col 0 and P2 in col 1, alternating. After P1's 4th drop in col 0 → game_over=1, winner=01, and busy stays high for ≤ 24 cycles.
- Diagonal win with WIN_LEN=3, COLS=ROWS=4: build a down-right diagonal for P2 → winner=10. Left/right presses in OVER do not move the cursor. A drop press clears the board and returns to IDLE with player 0.
- Draw: COLS=ROWS=4, WIN_LEN=4, with a no-win fill sequence → after the 16th piece game_over=1, winner=00.
- Reset mid-check: assert rst on the 2nd CHECK cycle → next cycle all cells read 00, busy=0, cursor_col=0.
